// File: rtl/adc128s_pkg.sv
// Shared types and constants for the ADC128S-class SPI A2D behavioural model.
// Channel map, frame length, frame-tracking states and command-word helpers.
package adc128s_pkg;

  typedef logic [2:0]  chan_t;
  typedef logic [11:0] sample_t;

  localparam chan_t   LFT_CH     = 3'd0;
  localparam chan_t   RGHT_CH    = 3'd4;
  localparam chan_t   BATT_CH    = 3'd5;
  localparam sample_t UNUSED_VAL = 12'h000;

  localparam int        FRAME_BITS = 16;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  // The channel field sits in bits [13:11] of the 16-bit command word.
  function automatic chan_t cmd_chan(input logic [15:0] cmd);
    return cmd[13:11];
  endfunction

  function automatic logic [15:0] pack_word(input sample_t s);
    return {4'b0000, s};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with rise/fall pulse generation for one SPI control line.
// valid_o marks when the synchronized level reflects the real input rather than reset.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic valid_o,
  output logic rise_o,
  output logic fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       hist_q;
  logic [1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
      vld_q  <= 2'b00;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign level_o = sync_q;
  assign valid_o = vld_q[1];
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/adc128s_spi_model.sv
// SPI mode-3 slave model of an 8-channel 12-bit A2D with a one-frame pipelined response.
// Optional frame checking is compiled in with `define ADC_FRAME_CHK_EN.
module adc128s_spi_model
  import adc128s_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  input  logic [11:0] batt_set
);

  logic ss_level, ss_valid, ss_rise, ss_fall;
  logic sclk_level, sclk_valid, sclk_rise, sclk_fall;

  spi_edge_sync u_ss_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (SS_n),
    .level_o (ss_level),
    .valid_o (ss_valid),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_edge_sync u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (SCLK),
    .level_o (sclk_level),
    .valid_o (sclk_valid),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  frame_state_e state_q, state_d;
  logic [15:0]  tx_shift_q, tx_shift_d;
  logic [15:0]  rx_shift_q, rx_shift_d;
  logic [4:0]   bit_cnt_q, bit_cnt_d;
  chan_t        prev_ch_q, prev_ch_d;
  logic         armed_q, armed_d;
  sample_t      sel_val;

  always_comb begin
    case (prev_ch_q)
      LFT_CH:  sel_val = lft_cell_set;
      RGHT_CH: sel_val = rght_cell_set;
      BATT_CH: sel_val = batt_set;
      default: sel_val = UNUSED_VAL;
    endcase
  end

  // Armed only once SS_n has genuinely been seen high, so a reset released
  // mid-frame does not mistake the reset-forced sync level for a falling edge.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    prev_ch_d  = prev_ch_q;
    armed_d    = armed_q;

    if (ss_valid && ss_level) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && armed_q) begin
          state_d    = ST_FRAME;
          tx_shift_d = pack_word(sel_val);
          bit_cnt_d  = 5'd0;
        end
      end
      ST_FRAME: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          if (bit_cnt_q == FRAME_CNT) begin
            prev_ch_d = cmd_chan(rx_shift_q);
          end
        end else begin
          if (sclk_rise && sclk_valid) begin
            rx_shift_d = {rx_shift_q[14:0], MOSI};
            if (bit_cnt_q != FRAME_CNT) begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          // The leading SCLK fall of mode 3 precedes any rise and must not shift.
          if (sclk_fall && sclk_valid && (bit_cnt_q != 5'd0)) begin
            tx_shift_d = {tx_shift_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= 16'h0000;
      rx_shift_q <= 16'h0000;
      bit_cnt_q  <= 5'd0;
      prev_ch_q  <= LFT_CH;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      prev_ch_q  <= prev_ch_d;
      armed_q    <= armed_d;
    end
  end

  assign MISO = (state_q == ST_FRAME) ? tx_shift_q[15] : 1'bz;

`ifdef ADC_FRAME_CHK_EN
  always @(posedge clk) begin
    if (rst_n && (state_q == ST_FRAME) && ss_rise) begin
      if (bit_cnt_q != FRAME_CNT) begin
        $error("adc128s_spi_model: aborted frame, %0d SCLK rises at time %0t", bit_cnt_q, $time);
      end else if ((rx_shift_q[15:14] != 2'b00) || (rx_shift_q[10:0] != 11'd0)) begin
        $warning("adc128s_spi_model: reserved command bits set (0x%04h) at time %0t", rx_shift_q, $time);
      end
    end
  end
`endif

  logic unused_levels;
  assign unused_levels = sclk_level;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed bench for adc128s_spi_model: a vector table of full frames plus
// hand-written sequences for mid-frame set changes, aborted frames and mid-frame reset.
module tb_adc128s_spi_model;

  localparam int HALF = 5;

  logic        clk;
  logic        rst_n;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  wire         miso_w;
  logic [11:0] lft_cell_set;
  logic [11:0] rght_cell_set;
  logic [11:0] batt_set;

  pullup (miso_w);

  adc128s_spi_model dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SS_n          (ss_n),
    .SCLK          (sclk),
    .MOSI          (mosi),
    .MISO          (miso_w),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set),
    .batt_set      (batt_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] batt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: got %04h", name, act);
    end else begin
      $display("FAIL %s: got %04h, expected %04h", name, act, exp);
    end
  endtask

  task automatic check_released(input string name);
    n_checks++;
    if (miso_w === 1'b1) begin
      n_pass++;
      $display("check %s: MISO released", name);
    end else begin
      $display("FAIL %s: MISO=%b, expected released (pulled to 1)", name, miso_w);
    end
  endtask

  task automatic do_frame(input logic [2:0] ch, input int nbits, input bit raise_ss,
                          input bit mid_chg, input logic [11:0] mid_lft,
                          output logic [15:0] word);
    logic [15:0] cmd;
    cmd  = {2'b00, ch, 11'd0};
    word = 16'h0000;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[15-i];
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      word[15-i] = miso_w;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (mid_chg && i == 7) lft_cell_set = mid_lft;
    end
    if (raise_ss) begin
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] w;

    vecs[0]  = '{3'd4, 12'h110, 12'h100, 12'hC00, 16'h0110};
    vecs[1]  = '{3'd5, 12'h110, 12'h100, 12'hC00, 16'h0100};
    vecs[2]  = '{3'd0, 12'h110, 12'h100, 12'hC00, 16'h0C00};
    vecs[3]  = '{3'd4, 12'h200, 12'h100, 12'hC00, 16'h0200};
    vecs[4]  = '{3'd0, 12'h200, 12'h004, 12'hC00, 16'h0004};
    vecs[5]  = '{3'd4, 12'h123, 12'h004, 12'hC00, 16'h0123};
    vecs[6]  = '{3'd0, 12'h123, 12'hABC, 12'hC00, 16'h0ABC};
    vecs[7]  = '{3'd4, 12'hFFF, 12'hABC, 12'hC00, 16'h0FFF};
    vecs[8]  = '{3'd0, 12'hFFF, 12'h004, 12'hC00, 16'h0004};
    vecs[9]  = '{3'd4, 12'h200, 12'h004, 12'hC00, 16'h0200};
    vecs[10] = '{3'd3, 12'h200, 12'h555, 12'hC00, 16'h0555};
    vecs[11] = '{3'd1, 12'h200, 12'h555, 12'hC00, 16'h0000};
    vecs[12] = '{3'd5, 12'h200, 12'h555, 12'hC00, 16'h0000};
    vecs[13] = '{3'd0, 12'h200, 12'h555, 12'h7A5, 16'h07A5};
    vecs[14] = '{3'd6, 12'h001, 12'h555, 12'h7A5, 16'h0001};
    vecs[15] = '{3'd0, 12'h001, 12'h555, 12'h7A5, 16'h0000};

    rst_n = 1'b0;
    ss_n  = 1'b1;
    sclk  = 1'b1;
    mosi  = 1'b0;
    lft_cell_set  = 12'h110;
    rght_cell_set = 12'h100;
    batt_set      = 12'hC00;
    repeat (4) @(negedge clk);
    check_released("reset_miso");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_released("idle_after_reset");

    for (int k = 0; k < 16; k++) begin
      lft_cell_set  = vecs[k].lft;
      rght_cell_set = vecs[k].rght;
      batt_set      = vecs[k].batt;
      do_frame(vecs[k].ch, 16, 1'b1, 1'b0, 12'h000, w);
      check16($sformatf("vec%0d_ch%0d", k, vecs[k].ch), w, vecs[k].exp);
    end
    check_released("idle_after_frames");

    // Set input changed mid-frame must not disturb the loaded word.
    lft_cell_set = 12'h321;
    do_frame(3'd5, 16, 1'b1, 1'b1, 12'h0EE, w);
    check16("mid_frame_set_change", w, 16'h0321);

    // Aborted frame keeps the previous channel (5 -> battery).
    do_frame(3'd4, 7, 1'b1, 1'b0, 12'h000, w);
    check_released("after_abort");
    do_frame(3'd0, 16, 1'b1, 1'b0, 12'h000, w);
    check16("after_abort_prev_ch", w, 16'h07A5);
    do_frame(3'd4, 16, 1'b1, 1'b0, 12'h000, w);
    check16("lft_after_mid_change", w, 16'h00EE);

    // Reset in the middle of a frame returning rght_cell_set.
    rght_cell_set = 12'h0F0;
    do_frame(3'd5, 9, 1'b0, 1'b0, 12'h000, w);
    check16("partial_before_reset", {7'd0, w[15:7]}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check_released("reset_mid_frame");
    repeat (3) @(negedge clk);
    sclk  = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_released("no_frame_without_ss_high");
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    lft_cell_set = 12'h0AA;
    do_frame(3'd4, 16, 1'b1, 1'b0, 12'h000, w);
    check16("first_after_reset", w, 16'h00AA);
    do_frame(3'd0, 16, 1'b1, 1'b0, 12'h000, w);
    check16("second_after_reset", w, 16'h00F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
